// File: rtl/dmem_responder_pkg.sv
// Memory-map constants shared by the data-memory responder and anything
// that decodes its MMIO window.
package dmem_responder_pkg;

  localparam logic [4:0] OFF_CYCLE  = 5'h00;
  localparam logic [4:0] OFF_TCMP   = 5'h04;
  localparam logic [4:0] OFF_TSTAT  = 5'h08;
  localparam logic [4:0] OFF_TXDATA = 5'h0C;
  localparam logic [4:0] OFF_TXSTAT = 5'h10;

  localparam int TSTAT_PEND     = 0;
  localparam int TXSTAT_FULL    = 0;
  localparam int TXSTAT_EMPTY   = 1;
  localparam int TXSTAT_OVF     = 2;
  localparam int TXSTAT_CNT_LSB = 8;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_responder_if.sv
// Core data port plus TX stream handshake and timer interrupt.
interface dmem_responder_if;
  logic        we_dm;
  logic [31:0] addr;
  logic [31:0] wd_dm;
  logic [31:0] rd_dm;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  modport slave  (input  we_dm, addr, wd_dm, out_ready,
                  output rd_dm, out_data, out_valid, irq);
  modport master (output we_dm, addr, wd_dm, out_ready,
                  input  rd_dm, out_data, out_valid, irq);
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Circular TX FIFO; head reads as zero while empty so the stream port is clean.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data RAM + MMIO (cycle counter, compare timer, TX FIFO) behind the core's
// memory-stage port. Reads are combinational and show pre-edge state.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_0800
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle, tcmp, txstat;
  logic          pending, ovf;
  logic          ram_sel, mmio_sel, wr_mmio;
  logic [4:0]    off;
  logic          tcmp_wr, pend_clr, tx_push, ovf_clr, ovf_set;
  logic          full, empty;
  logic [CW-1:0] count;

  assign ram_sel  = bus.addr < MMIO_BASE;
  assign mmio_sel = (bus.addr >= MMIO_BASE) && (bus.addr < MMIO_BASE + 32'h20);
  assign off      = {bus.addr[4:2], 2'b00};
  assign wr_mmio  = bus.we_dm && mmio_sel;

  assign tcmp_wr  = wr_mmio && (off == OFF_TCMP);
  assign pend_clr = wr_mmio && (off == OFF_TSTAT)  && bus.wd_dm[TSTAT_PEND];
  assign tx_push  = wr_mmio && (off == OFF_TXDATA);
  assign ovf_clr  = wr_mmio && (off == OFF_TXSTAT) && bus.wd_dm[TXSTAT_OVF];
  // full implies non-empty, so only out_ready decides whether a pop rescues the push
  assign ovf_set  = tx_push && full && !bus.out_ready;

  always_ff @(posedge clk)
    if (bus.we_dm && ram_sel) ram[bus.addr[AW+1:2]] <= bus.wd_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle   <= '0;
      tcmp    <= TCMP_RST;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cycle   <= cycle + 32'd1;
      if (tcmp_wr) tcmp <= bus.wd_dm;
      // set wins over a coincident clear for both sticky flags
      pending <= (cycle == tcmp) || (pending && !pend_clr);
      ovf     <= ovf_set || (ovf && !ovf_clr);
    end
  end

  tx_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (bus.wd_dm),
    .pop   (bus.out_ready),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (bus.out_data)
  );

  assign bus.out_valid = !empty;
  assign bus.irq       = pending;

  always_comb begin
    txstat                          = '0;
    txstat[TXSTAT_FULL]             = full;
    txstat[TXSTAT_EMPTY]            = empty;
    txstat[TXSTAT_OVF]              = ovf;
    txstat[TXSTAT_CNT_LSB +: 8]     = 8'(count);
  end

  always_comb begin
    bus.rd_dm = '0;
    if (ram_sel) begin
      bus.rd_dm = ram[bus.addr[AW+1:2]];
    end else if (mmio_sel) begin
      case (off)
        OFF_CYCLE:  bus.rd_dm = cycle;
        OFF_TCMP:   bus.rd_dm = tcmp;
        OFF_TSTAT:  bus.rd_dm = {31'd0, pending};
        OFF_TXSTAT: bus.rd_dm = txstat;
        default:    bus.rd_dm = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder against a queue/array model.
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h0000_0800;
  localparam int NW = 64;
  localparam int FD = 8;

  logic clk, rst;
  dmem_responder_if bus();

  dmem_responder #(.RAM_WORDS(NW), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit [31:0] m_ram [NW];
  bit        m_ramv [NW];
  bit [31:0] m_cyc, m_tcmp;
  bit        m_pend, m_ovf;
  bit [31:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mmio(input bit [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h20);
  endfunction

  // Expected read value; returns 0 when the word is an unwritten RAM location.
  function automatic bit exp_rd(input bit [31:0] a, output bit [31:0] v);
    bit [31:0] o;
    int idx;
    v = 32'd0;
    if (a < BASE) begin
      idx = int'((a >> 2) % NW);
      v = m_ram[idx];
      return m_ramv[idx];
    end
    if (!is_mmio(a)) return 1'b1;
    o = (a - BASE) & 32'h1C;
    case (o)
      32'h00: v = m_cyc;
      32'h04: v = m_tcmp;
      32'h08: v = {31'd0, m_pend};
      32'h10: v = (32'(q.size()) << 8) | {29'd0, m_ovf, q.size() == 0, q.size() == FD};
      default: v = 32'd0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_tcmp = 32'hFFFF_FFFF; m_pend = 0; m_ovf = 0;
    q.delete();
  endtask

  task automatic model_edge(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit rdy);
    bit [31:0] o;
    bit mm, popd, setp, ovfset, clr_p, clr_o;
    int n;
    mm = is_mmio(a);
    o = (a - BASE) & 32'h1C;
    n = q.size();
    popd = rdy && (n > 0);
    setp = (m_cyc == m_tcmp);
    clr_p = we && mm && (o == 32'h08) && wd[0];
    clr_o = we && mm && (o == 32'h10) && wd[2];
    ovfset = 0;
    if (we && a < BASE) begin
      m_ram[(a >> 2) % NW] = wd;
      m_ramv[(a >> 2) % NW] = 1'b1;
    end
    if (we && mm && o == 32'h04) m_tcmp = wd;
    if (popd) void'(q.pop_front());
    if (we && mm && o == 32'h0C) begin
      if (n < FD || popd) q.push_back(wd);
      else ovfset = 1;
    end
    m_ovf = ovfset | (m_ovf & !clr_o);
    m_pend = setp | (m_pend & !clr_p);
    m_cyc = m_cyc + 1;
  endtask

  task automatic check_outputs(input string tag);
    bit [31:0] v;
    if (exp_rd(bus.addr, v)) chk({tag, ":rd"}, bus.rd_dm, v);
    chk({tag, ":valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    chk({tag, ":data"}, bus.out_data, (q.size() > 0) ? q[0] : 32'd0);
    chk({tag, ":irq"}, 32'(bus.irq), 32'(m_pend));
  endtask

  // One clock: inputs driven at posedge+1, outputs sampled mid-cycle.
  task automatic cyc(input string tag, input bit we, input bit [31:0] a,
                     input bit [31:0] wd, input bit rdy);
    bus.we_dm = we; bus.addr = a; bus.wd_dm = wd; bus.out_ready = rdy;
    #4;
    check_outputs(tag);
    @(posedge clk);
    model_edge(we, a, wd, rdy);
    #1;
  endtask

  task automatic do_reset(input string tag);
    bus.we_dm = 0; bus.out_ready = 0; bus.wd_dm = 0;
    bus.addr = BASE + 32'h10;
    #1 rst = 0;
    #1;
    chk({tag, ":valid0"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ":irq0"}, 32'(bus.irq), 32'd0);
    chk({tag, ":data0"}, bus.out_data, 32'd0);
    chk({tag, ":txstat0"}, bus.rd_dm, 32'h0000_0002);
    bus.addr = BASE;
    #1;
    chk({tag, ":cycle0"}, bus.rd_dm, 32'd0);
    model_reset();
    #1 rst = 1;
    @(posedge clk);
    model_edge(0, BASE, 0, 0);
    #1;
    bus.addr = BASE + 32'h4;
    #1;
    chk({tag, ":tcmp_rst"}, bus.rd_dm, 32'hFFFF_FFFF);
    #3;
    @(posedge clk);
    model_edge(0, BASE + 32'h4, 0, 0);
    #1;
  endtask

  initial begin
    bit [31:0] tgt, a, wd;
    rst = 0;
    bus.we_dm = 0; bus.addr = 0; bus.wd_dm = 0; bus.out_ready = 0;
    for (int i = 0; i < NW; i++) m_ramv[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("por");

    // RAM write/read and aliasing
    cyc("ram_w10", 1, 32'h10, 32'hDEAD_BEEF, 0);
    cyc("ram_w14", 1, 32'h14, 32'h1234_5678, 0);
    cyc("ram_r10", 0, 32'h10, 0, 0);
    cyc("ram_r14", 0, 32'h14, 0, 0);
    bus.addr = 32'h110; #1;
    chk("ram_alias", bus.rd_dm, 32'hDEAD_BEEF);
    #1;
    cyc("ram_r112", 0, 32'h112, 0, 0);
    cyc("rdw_same", 1, 32'h10, 32'h0BAD_F00D, 0);
    cyc("rdw_next", 0, 32'h10, 0, 0);

    // cycle counter and timer
    repeat (3) cyc("cycle", 0, BASE, 0, 0);
    tgt = m_cyc + 4;
    cyc("tcmp_w", 1, BASE + 32'h4, tgt, 0);
    cyc("tcmp_r", 0, BASE + 32'h4, 0, 0);
    repeat (6) cyc("timer", 0, BASE + 32'h8, 0, 0);
    chk("irq_set", 32'(bus.irq), 32'd1);
    cyc("tstat_clr", 1, BASE + 32'h8, 32'h1, 0);
    cyc("after_clr", 0, BASE + 32'h8, 0, 0);
    chk("irq_clr", 32'(bus.irq), 32'd0);
    tgt = m_cyc + 3;
    cyc("tcmp_w2", 1, BASE + 32'h4, tgt, 0);
    for (int i = 0; i < 10 && m_cyc != tgt; i++) cyc("wait_match", 0, BASE, 0, 0);
    cyc("clr_on_set", 1, BASE + 32'h8, 32'h1, 0);
    cyc("irq_kept", 0, BASE + 32'h8, 0, 0);
    chk("irq_clr_loses", 32'(bus.irq), 32'd1);
    cyc("tstat_clr2", 1, BASE + 32'h8, 32'h1, 0);

    // FIFO fill, overflow, drain
    for (int i = 1; i <= FD; i++) cyc("push", 1, BASE + 32'hC, 32'(i), 0);
    cyc("full_stat", 0, BASE + 32'h10, 0, 0);
    cyc("push_ovf", 1, BASE + 32'hC, 32'h99, 0);
    bus.addr = BASE + 32'h10; #1;
    chk("ovf_stat", bus.rd_dm, 32'h0000_0805);
    #1;
    for (int i = 0; i < FD + 1; i++) cyc("drain", 0, BASE + 32'h10, 0, 1);
    cyc("ovf_clr", 1, BASE + 32'h10, 32'h4, 0);
    cyc("after_ovf_clr", 0, BASE + 32'h10, 0, 0);

    // push while full with a simultaneous pop
    for (int i = 0; i < FD; i++) cyc("refill", 1, BASE + 32'hC, 32'h100 + 32'(i), 0);
    cyc("push_pop_full", 1, BASE + 32'hC, 32'hAA, 1);
    cyc("pp_stat", 0, BASE + 32'h10, 0, 0);
    for (int i = 0; i < FD + 1; i++) cyc("drain2", 0, BASE + 32'h10, 0, 1);
    cyc("push_empty_pop", 1, BASE + 32'hC, 32'h55, 1);
    cyc("pe_stat", 0, BASE + 32'h10, 0, 0);
    cyc("pe_drain", 0, BASE + 32'h10, 0, 1);

    // async reset with data queued and pending set
    for (int i = 0; i < 3; i++) cyc("pre_rst_push", 1, BASE + 32'hC, 32'h70 + 32'(i), 0);
    cyc("pre_rst_tcmp", 1, BASE + 32'h4, m_cyc + 1, 0);
    repeat (2) cyc("pre_rst_wait", 0, BASE + 32'h8, 0, 0);
    chk("pre_rst_irq", 32'(bus.irq), 32'd1);
    do_reset("midrst");

    // unmapped addresses
    cyc("um18_w", 1, BASE + 32'h18, 32'hFFFF_FFFF, 0);
    cyc("um40_w", 1, BASE + 32'h40, 32'hFFFF_FFFF, 0);
    cyc("um18_r", 0, BASE + 32'h18, 0, 0);
    cyc("um40_r", 0, BASE + 32'h40, 0, 0);
    cyc("um_tcmp", 0, BASE + 32'h4, 0, 0);
    cyc("um_stat", 0, BASE + 32'h10, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: a = $urandom_range(0, 32'h7FF);
        3:       a = BASE + 32'h20 + $urandom_range(0, 32'h7DF);
        default: a = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      endcase
      wd = $urandom;
      if (is_mmio(a) && ((a - BASE) & 32'h1C) == 32'h04) wd = m_cyc + $urandom_range(1, 8);
      cyc("rand", $urandom_range(0, 1) == 1, a, wd, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS32 core: the slave end of the core's memory-stage data port (address, write enable, write data in; read data out). It serves a word-addressed data RAM plus a small MMIO window holding a free-running cycle counter, a compare timer with a sticky interrupt flag, and a TX FIFO. The TX FIFO drains to an external consumer over a valid/ready handshake. It sits beside the core at the top level and replaces the flat data memory.

## Interface
Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- MMIO_BASE, 32'h0000_0800, byte address of the MMIO window; aligned to 0x20.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- we_dm  in  1  write strobe from the core's memory stage.
- addr  in  32  byte address from the core's ALU result.
- wd_dm  in  32  write data.
- rd_dm  out  32  read data; combinational in addr and current state.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- irq  out  1  timer pending flag (registered).

## Operation
- Decode: addr < MMIO_BASE selects RAM, index = addr[log2(RAM_WORDS)+1:2]. Higher RAM-region addresses alias modulo RAM size. addr[1:0] is ignored everywhere.
- MMIO_BASE ≤ addr < MMIO_BASE+0x20 selects MMIO at offset addr[4:0]. All other addresses read 0; writes to them are ignored.
- MMIO map:
  - 0x00 CYCLE: RO, free-running counter.
  - 0x04 TIMER_CMP: RW.
  - 0x08 TIMER_STAT: bit0 pending; write 1 to clear.
  - 0x0C TX_DATA: WO, push; reads 0.
  - 0x10 TX_STAT: bit0 full, bit1 empty, bit2 overflow (W1C), bits[15:8] occupancy count.
  - 0x14–0x1C: reserved; read 0, writes ignored.
- RAM: write at the edge when we_dm and RAM selected. Read is asynchronous.
- Read-during-write to the same word returns the old data; the new data is visible the next cycle.
- Cycle counter: +1 every cycle, wraps 0xFFFF_FFFF→0.
- Timer: at each edge, if CYCLE == TIMER_CMP (pre-edge values), pending ← 1. A W1C write in the same cycle as a set loses, so pending stays 1.
- irq = pending.
- TX FIFO: a TX_DATA write pushes wd_dm. Pop occurs when out_valid && out_ready.
- Push is accepted if !full or a pop happens in the same cycle.
- A rejected push sets the overflow flag and leaves the FIFO unchanged. Overflow is cleared only by W1C and is held if a clear and a new overflow coincide.
- Simultaneous push and pop when empty: only the push takes effect, because out_valid is 0.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

## Timing
- Reset values:
  - CYCLE = 0.
  - TIMER_CMP = 0xFFFF_FFFF.
  - pending = 0, irq = 0.
  - FIFO empty: out_valid = 0, count = 0, overflow = 0.
  - out_data = 0 while empty.
  - RAM is not reset; its contents are undefined.
- Reset mid-operation discards FIFO contents immediately, asynchronously, and clears all the state listed above.
- rd_dm has zero-cycle latency. MMIO reads reflect state before the current edge.
- Writes have effect after one edge. Example: a TIMER_CMP write followed by a read on the next cycle returns the new value.
- out_data/out_valid change only after an edge. Once out_valid is asserted, out_data is stable until popped.
- A push into an empty FIFO raises out_valid on the following cycle.
- The pending flag is visible on irq one cycle after the cycle in which CYCLE equalled TIMER_CMP.

## Structure
- The shared memory-map package/header holds:
  - MMIO offsets: OFF_CYCLE, OFF_TCMP, OFF_TSTAT, OFF_TXDATA, OFF_TXSTAT.
  - Status bit positions.
  - The TIMER_CMP reset constant.
- One sub-module, tx_fifo: parameterised depth, push/pop/full/empty/count, head output, async active-low reset.
- Decode, RAM, counter/timer and the read mux live in dmem_responder.

## Test plan
- Reset then RAM access: write 0xDEAD_BEEF to 0x10 and 0x12345678 to 0x14, read both back. Read 0x110 with RAM_WORDS=64 → 0xDEAD_BEEF (alias).
- Cycle counter: release reset, read CYCLE at N cycles → N. Force TIMER_CMP = 5 → irq rises on the edge after CYCLE reads 5. Write 1 to TIMER_STAT → irq 0 next cycle. A clear on the set cycle → irq stays 1.
- FIFO with out_ready=0: push 8 words 1..8 → TX_STAT full=1, count=8. Push a 9th word → overflow=1, contents unchanged. Raise out_ready → out_data sequence 1..8, then out_valid=0, empty=1.
- Push while full with out_ready=1 in the same cycle → accepted, count stays 8, overflow stays 0.
- Assert rst with 3 words queued and pending=1 → out_valid, irq, count and CYCLE are 0 asynchronously. TIMER_CMP reads 0xFFFF_FFFF after release.
- Unmapped MMIO_BASE+0x18 and MMIO_BASE+0x40 reads → 0; writes to them change no state.
